// File: rtl/sevseg_pkg.sv
// Shared constants and types for the seven-segment scan path.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package sevseg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Index 15 is the leftmost element of the concatenation, index 0 the rightmost.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [3:0] an_onecold(input digit_idx_t idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

  // A digit is a leading zero when it and every more significant digit are zero.
  function automatic logic lz_blank(input digit_idx_t idx,
                                    input logic [3:0] v2,
                                    input logic [3:0] v3,
                                    input logic [3:0] v4);
    logic blank;
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (v4 == 4'h0);
      2'd2:    blank = (v4 == 4'h0) && (v3 == 4'h0);
      2'd1:    blank = (v4 == 4'h0) && (v3 == 4'h0) && (v2 == 4'h0);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern lookup.
module sevseg_hex_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_LUT[hex];
  end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed common-anode driver for four hex digits with dead time,
// leading-zero blanking and blink of the digit under edit.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_BITS   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value1,
  input  logic [3:0] value2,
  input  logic [3:0] value3,
  input  logic [3:0] value4,
  input  logic [1:0] sel,
  input  logic       edit_en,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam logic [REFRESH_BITS-1:0] DEAD_LIM = REFRESH_BITS'(DEAD_CYCLES);

  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  digit_idx_t              idx_q, idx_d;
  logic [BLINK_BITS-1:0]   blink_q, blink_d;
  logic [3:0]              digit_q, digit_d;
  logic                    lz_q, lz_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    tick_q, tick_d;

  logic       slot_start;
  logic       presc_wrap;
  logic [3:0] cap_digit;
  logic       cap_lz;
  logic       dead;
  logic       blink_dark;
  logic       dark;
  logic [6:0] dec_seg;

  sevseg_hex_decode u_decode (
    .hex (digit_d),
    .seg (dec_seg)
  );

  always_comb begin
    cap_digit = value1;
    case (idx_q)
      2'd0:    cap_digit = value1;
      2'd1:    cap_digit = value2;
      2'd2:    cap_digit = value3;
      default: cap_digit = value4;
    endcase
  end

  always_comb begin
    slot_start = (presc_q == '0);
    presc_wrap = (presc_q == '1);
    presc_d    = presc_q + 1'b1;
    idx_d      = presc_wrap ? digit_idx_t'(idx_q + 2'd1) : idx_q;
    tick_d     = presc_wrap && (idx_q == 2'd3);
    blink_d    = blink_q + 1'b1;

    cap_lz  = blank_lz && lz_blank(idx_q, value2, value3, value4);
    // digit_d/lz_d double as the effective values for this slot, so the
    // freshly captured digit is shown even if the dead time were zero.
    digit_d = slot_start ? cap_digit : digit_q;
    lz_d    = slot_start ? cap_lz    : lz_q;

    dead       = (presc_q < DEAD_LIM);
    blink_dark = edit_en && (idx_q == sel) && blink_q[BLINK_BITS-1];
    dark       = dead || lz_d || blink_dark;

    an_d  = dark ? AN_OFF  : an_onecold(idx_q);
    seg_d = dark ? SEG_OFF : dec_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      blink_q <= '0;
      digit_q <= 4'h0;
      lz_q    <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      digit_q <= digit_d;
      lz_q    <= lz_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed self-checking bench for sevseg_scan_driver with a short refresh
// period (64-clock slots, 4 dead clocks, 256-clock blink period).
module tb_sevseg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] value1, value2, value3, value4;
  logic [1:0] sel;
  logic       edit_en;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int tick_cnt     = 0;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  sevseg_scan_driver #(
    .REFRESH_BITS (6),
    .DEAD_CYCLES  (4),
    .BLINK_BITS   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value1     (value1),
    .value2     (value2),
    .value3     (value3),
    .value4     (value4),
    .sel        (sel),
    .edit_en    (edit_en),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    check({tag, "_an"}, 8'(an), 8'(exp_an));
    check({tag, "_seg"}, 8'(seg), 8'(exp_seg));
  endtask

  // Advance to the n-th rising edge after reset release, checking invariants each clock.
  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_tick === 1'b1) tick_cnt++;
      check("an_at_most_one_low",
            8'((an == 4'hF) || (an == 4'hE) || (an == 4'hD) || (an == 4'hB) || (an == 4'h7)),
            8'd1);
      check("seg_off_when_dark", 8'((an != 4'hF) || (seg == 7'h7F)), 8'd1);
      check("dp_off", 8'(dp), 8'd1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("in_reset", 4'hF, 7'h7F);
    check("in_reset_tick", 8'(frame_tick), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tick_cnt = 0;
  endtask

  initial begin
    value1 = 4'h1; value2 = 4'h2; value3 = 4'h3; value4 = 4'h4;
    sel = 2'd0; edit_en = 1'b0; blank_lz = 1'b0;

    // Basic scan order, dead time and frame tick
    do_reset();
    check_output("after_release", 4'hF, 7'h7F);
    run_to(4);   check_output("dead_d0", 4'hF, 7'h7F);
    run_to(5);   check_output("lit_d0_first", 4'hE, 7'h79);
    run_to(64);  check_output("lit_d0_last", 4'hE, 7'h79);
    run_to(65);  check_output("dead_d1_first", 4'hF, 7'h7F);
    run_to(68);  check_output("dead_d1_last", 4'hF, 7'h7F);
    run_to(69);  check_output("lit_d1", 4'hD, 7'h24);
    run_to(133); check_output("lit_d2", 4'hB, 7'h30);
    run_to(197); check_output("lit_d3", 4'h7, 7'h19);
    run_to(255); check("tick_before_wrap", 8'(frame_tick), 8'd0);
    run_to(256); check("tick_at_wrap", 8'(frame_tick), 8'd1);
    check_output("lit_d3_last", 4'h7, 7'h19);
    run_to(257); check("tick_after_wrap", 8'(frame_tick), 8'd0);
    check_output("dead_frame1", 4'hF, 7'h7F);

    // Mid-slot input change is held off until the next visit of that digit
    run_to(543); value1 = 4'h8;
    run_to(560); check_output("midslot_hold", 4'hE, 7'h79);
    run_to(576); check_output("midslot_hold_end", 4'hE, 7'h79);
    run_to(577); check_output("midslot_next_dead", 4'hF, 7'h7F);
    run_to(773); check_output("midslot_new_value", 4'hE, 7'h00);
    check("frame_tick_count", 8'(tick_cnt), 8'd3);

    // Asynchronous reset while a digit is lit
    #2 rst_n = 1'b0;
    #1 check_output("async_reset_lit", 4'hF, 7'h7F);
    check("async_reset_lit_tick", 8'(frame_tick), 8'd0);
    value1 = 4'h1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run_to(5);   check_output("restart_d0", 4'hE, 7'h79);
    run_to(256); check("tick_before_async", 8'(frame_tick), 8'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_tick", 8'(frame_tick), 8'd0);
    check_output("async_reset_tick_out", 4'hF, 7'h7F);

    // Leading-zero blanking
    value1 = 4'h5; value2 = 4'h0; value3 = 4'h0; value4 = 4'h0; blank_lz = 1'b1;
    do_reset();
    run_to(5);   check_output("lz_d0_lit", 4'hE, 7'h12);
    run_to(69);  check_output("lz_d1_blank", 4'hF, 7'h7F);
    run_to(100); check_output("lz_d1_blank_mid", 4'hF, 7'h7F);
    run_to(133); check_output("lz_d2_blank", 4'hF, 7'h7F);
    run_to(197); check_output("lz_d3_blank", 4'hF, 7'h7F);
    run_to(261); check_output("lz_d0_again", 4'hE, 7'h12);
    value3 = 4'h3;
    run_to(325); check_output("lz_d1_inner_zero", 4'hD, 7'h40);
    run_to(389); check_output("lz_d2_nonzero", 4'hB, 7'h30);
    run_to(453); check_output("lz_d3_still_blank", 4'hF, 7'h7F);
    blank_lz = 1'b0; value3 = 4'h0;
    run_to(460); check_output("lz_flag_held", 4'hF, 7'h7F);
    run_to(581); check_output("nolz_d1", 4'hD, 7'h40);
    run_to(645); check_output("nolz_d2", 4'hB, 7'h40);
    run_to(709); check_output("nolz_d3", 4'h7, 7'h40);

    // Blink of the digit under edit
    value1 = 4'h1; value2 = 4'h2; value3 = 4'h3; value4 = 4'h4;
    edit_en = 1'b1; sel = 2'd2;
    do_reset();
    run_to(5);   check_output("blink_d0_unaffected", 4'hE, 7'h79);
    run_to(69);  check_output("blink_d1_unaffected", 4'hD, 7'h24);
    run_to(133); check_output("blink_d2_dark", 4'hF, 7'h7F);
    run_to(170); check_output("blink_d2_dark_mid", 4'hF, 7'h7F);
    run_to(197); check_output("blink_d3_unaffected", 4'h7, 7'h19);
    sel = 2'd1;
    run_to(325); check_output("blink_sel1_phase0_lit", 4'hD, 7'h24);
    sel = 2'd3;
    run_to(453); check_output("blink_sel3_phase1_dark", 4'hF, 7'h7F);
    run_to(460); check_output("blink_sel3_dark_mid", 4'hF, 7'h7F);
    edit_en = 1'b0;
    run_to(461); check_output("blink_edit_off_live", 4'h7, 7'h19);

    // Decode sweep on digit 0
    value1 = 4'h0; value2 = 4'h1; value3 = 4'h2; value4 = 4'h3;
    sel = 2'd0; edit_en = 1'b0; blank_lz = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        run_to(k * 256);
        value1 = 4'(k);
      end
      run_to(k * 256 + 5);
      check_output($sformatf("decode_%0h", k), 4'hE, HEX_SEG[k]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
